s4_write_arbiter: RTL and testbench

Round-robin write-path arbiter for Slave 4 (S4) of the 4-master / 7-slave AXI interconnect. It grants one of NUM_M masters the S4 AW channel and then the W channel for the complete burst, up to WLAST. It steers the AW/W valid/ready handshakes and provides mux selects for the external payload muxes. It also caps the number of outstanding (B-pending) writes to S4.

---
 rtl/s4_write_arbiter.sv | 139 +++++++++++++
 tb/tb_s4_write_arbiter.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s4_write_arbiter.sv
// s4_write_arbiter: round-robin write-path arbiter for AXI slave 4.
// Grants one master the AW channel, then holds the W channel for that master
// until WLAST, and limits the number of writes still waiting for a B response.
module s4_write_arbiter #(
  parameter int NUM_M           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_W           = $clog2(NUM_M),
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [NUM_M-1:0] M_AWVALID,
  output logic [NUM_M-1:0] M_AWREADY,
  input  logic [NUM_M-1:0] M_WVALID,
  input  logic [NUM_M-1:0] M_WLAST,
  output logic [NUM_M-1:0] M_WREADY,
  output logic             S4_AWVALID,
  input  logic             S4_AWREADY,
  output logic             S4_WVALID,
  output logic             S4_WLAST,
  input  logic             S4_WREADY,
  input  logic             S4_BVALID,
  input  logic             S4_BREADY,
  output logic [SEL_W-1:0] AW_SEL,
  output logic [SEL_W-1:0] W_SEL,
  output logic [CNT_W-1:0] OUTSTANDING,
  output logic             B_UNDERFLOW
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             b_underflow_q, b_underflow_d;

  logic             req_found;
  logic [SEL_W-1:0] winner;
  logic             grant_ok;
  logic [NUM_M-1:0] sel_onehot;
  logic             aw_hs;
  logic             w_last_hs;
  logic             b_hs;

  // Scan requesters upward from the round-robin pointer and take the first one.
  always_comb begin
    int cand;
    req_found = 1'b0;
    winner    = '0;
    cand      = 0;
    for (int i = 0; i < NUM_M; i++) begin
      cand = (int'(ptr_q) + i) % NUM_M;
      if (!req_found && M_AWVALID[cand]) begin
        req_found = 1'b1;
        winner    = SEL_W'(cand);
      end
    end
  end

  // Handshake steering; readies depend only on registered state, sel and S4 readies.
  always_comb begin
    sel_onehot = {{(NUM_M-1){1'b0}}, 1'b1} << sel_q;
    S4_AWVALID = (state_q == ADDR) && M_AWVALID[sel_q];
    M_AWREADY  = (state_q == ADDR && S4_AWREADY) ? sel_onehot : '0;
    S4_WVALID  = (state_q == DATA) && M_WVALID[sel_q];
    S4_WLAST   = (state_q == DATA) && M_WLAST[sel_q];
    M_WREADY   = (state_q == DATA && S4_WREADY) ? sel_onehot : '0;
    aw_hs      = S4_AWVALID && S4_AWREADY;
    w_last_hs  = S4_WVALID && S4_WREADY && S4_WLAST;
    b_hs       = S4_BVALID && S4_BREADY;
    grant_ok   = req_found && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  end

  // Next-state logic for the FSM, the grant select and the rotating pointer.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          state_d = ADDR;
          sel_d   = winner;
          ptr_d   = SEL_W'((int'(winner) + 1) % NUM_M);
        end
      end
      ADDR: begin
        if (aw_hs) state_d = DATA;
      end
      DATA: begin
        if (w_last_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding count: AW adds one, B removes one, both together cancel out.
  always_comb begin
    outstanding_d = outstanding_q;
    b_underflow_d = b_underflow_q;
    if (aw_hs && !b_hs) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (b_hs && !aw_hs) begin
      if (outstanding_q == '0) begin
        b_underflow_d = 1'b1;
      end else begin
        outstanding_d = outstanding_q - CNT_W'(1);
      end
    end
  end

  // All arbiter state registers; reset abandons any burst in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q       <= IDLE;
      sel_q         <= '0;
      ptr_q         <= '0;
      outstanding_q <= '0;
      b_underflow_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      ptr_q         <= ptr_d;
      outstanding_q <= outstanding_d;
      b_underflow_q <= b_underflow_d;
    end
  end

  assign AW_SEL      = sel_q;
  assign W_SEL       = sel_q;
  assign OUTSTANDING = outstanding_q;
  assign B_UNDERFLOW = b_underflow_q;

endmodule

// File: tb/tb_s4_write_arbiter.sv
// Directed self-checking bench for s4_write_arbiter (NUM_M=4, MAX_OUTSTANDING=4).
module tb_s4_write_arbiter;

  logic       ACLK;
  logic       ARESET;
  logic [3:0] M_AWVALID;
  logic [3:0] M_AWREADY;
  logic [3:0] M_WVALID;
  logic [3:0] M_WLAST;
  logic [3:0] M_WREADY;
  logic       S4_AWVALID;
  logic       S4_AWREADY;
  logic       S4_WVALID;
  logic       S4_WLAST;
  logic       S4_WREADY;
  logic       S4_BVALID;
  logic       S4_BREADY;
  logic [1:0] AW_SEL;
  logic [1:0] W_SEL;
  logic [2:0] OUTSTANDING;
  logic       B_UNDERFLOW;

  int checks   = 0;
  int failures = 0;

  s4_write_arbiter #(
    .NUM_M(4),
    .MAX_OUTSTANDING(4)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .M_AWVALID(M_AWVALID),
    .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID),
    .M_WLAST(M_WLAST),
    .M_WREADY(M_WREADY),
    .S4_AWVALID(S4_AWVALID),
    .S4_AWREADY(S4_AWREADY),
    .S4_WVALID(S4_WVALID),
    .S4_WLAST(S4_WLAST),
    .S4_WREADY(S4_WREADY),
    .S4_BVALID(S4_BVALID),
    .S4_BREADY(S4_BREADY),
    .AW_SEL(AW_SEL),
    .W_SEL(W_SEL),
    .OUTSTANDING(OUTSTANDING),
    .B_UNDERFLOW(B_UNDERFLOW)
  );

  // 100 MHz clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic clear_inputs();
    M_AWVALID  = '0;
    M_WVALID   = '0;
    M_WLAST    = '0;
    S4_AWREADY = 1'b0;
    S4_WREADY  = 1'b0;
    S4_BVALID  = 1'b0;
    S4_BREADY  = 1'b0;
  endtask

  task automatic apply_reset();
    ARESET = 1'b1;
    clear_inputs();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    ARESET     = 1'b1;
    M_AWVALID  = 4'b1111;
    M_WVALID   = 4'b1111;
    M_WLAST    = 4'b1111;
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    S4_BVALID  = 1'b0;
    S4_BREADY  = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({S4_AWVALID, S4_WVALID, S4_WLAST} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_s4_valids: got %b required 000", {S4_AWVALID, S4_WVALID, S4_WLAST});
    end
    checks++;
    if ({M_AWREADY, M_WREADY} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_m_readies: got %h required 00", {M_AWREADY, M_WREADY});
    end
    checks++;
    if ({AW_SEL, W_SEL} !== 4'h0) begin
      failures++;
      $display("[TB] FAIL reset_sel: got %h required 0", {AW_SEL, W_SEL});
    end
    checks++;
    if (OUTSTANDING !== 3'd0 || B_UNDERFLOW !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_counter: got cnt=%0d uf=%b required cnt=0 uf=0", OUTSTANDING, B_UNDERFLOW);
    end
    apply_reset();
  endtask

  task automatic test_single_write();
    int aw_cnt = 0;
    int w_cnt  = 0;
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    M_AWVALID  = 4'b0100;
    tick();
    checks++;
    if (AW_SEL !== 2'd2 || S4_AWVALID !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_grant: got sel=%0d awvalid=%b required sel=2 awvalid=1", AW_SEL, S4_AWVALID);
    end
    checks++;
    if (M_AWREADY !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL single_awready: got %b required 0100", M_AWREADY);
    end
    if (S4_AWVALID && S4_AWREADY) aw_cnt++;
    tick();
    M_AWVALID = '0;
    M_WVALID  = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      M_WLAST = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      if (S4_AWVALID && S4_AWREADY) aw_cnt++;
      if (S4_WVALID && S4_WREADY) w_cnt++;
      checks++;
      if (S4_WLAST !== (b == 3)) begin
        failures++;
        $display("[TB] FAIL single_wlast_beat%0d: got %b required %b", b, S4_WLAST, (b == 3));
      end
      tick();
    end
    M_WVALID = '0;
    M_WLAST  = '0;
    #1;
    checks++;
    if (aw_cnt !== 1 || w_cnt !== 4) begin
      failures++;
      $display("[TB] FAIL single_handshakes: got aw=%0d w=%0d required aw=1 w=4", aw_cnt, w_cnt);
    end
    checks++;
    if (OUTSTANDING !== 3'd1 || S4_WVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL single_outstanding_pre_b: got cnt=%0d wvalid=%b required cnt=1 wvalid=0", OUTSTANDING, S4_WVALID);
    end
    S4_BVALID = 1'b1;
    S4_BREADY = 1'b1;
    tick();
    S4_BVALID = 1'b0;
    S4_BREADY = 1'b0;
    checks++;
    if (OUTSTANDING !== 3'd0) begin
      failures++;
      $display("[TB] FAIL single_outstanding_post_b: got %0d required 0", OUTSTANDING);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] grants [5];
    int ng = 0;
    apply_reset();
    M_AWVALID  = 4'b1111;
    M_WVALID   = 4'b1111;
    M_WLAST    = 4'b1111;
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      S4_BVALID = (OUTSTANDING != 3'd0);
      S4_BREADY = (OUTSTANDING != 3'd0);
      #1;
      if (S4_AWVALID && S4_AWREADY) begin
        grants[ng] = AW_SEL;
        ng++;
      end
      tick();
    end
    checks++;
    if (ng !== 5) begin
      failures++;
      $display("[TB] FAIL rr_grant_count: got %0d required 5", ng);
    end
    for (int k = 0; k < ng; k++) begin
      checks++;
      if (grants[k] !== 2'(k % 4)) begin
        failures++;
        $display("[TB] FAIL rr_order_%0d: got %0d required %0d", k, grants[k], k % 4);
      end
    end
    clear_inputs();
  endtask

  task automatic test_outstanding_limit();
    apply_reset();
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    M_AWVALID  = 4'b0001;
    M_WVALID   = 4'b0001;
    M_WLAST    = 4'b0001;
    repeat (16) tick();
    checks++;
    if (OUTSTANDING !== 3'd4) begin
      failures++;
      $display("[TB] FAIL limit_count: got %0d required 4", OUTSTANDING);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (S4_AWVALID !== 1'b0 || M_WREADY !== 4'b0000) begin
        failures++;
        $display("[TB] FAIL limit_blocked_%0d: got awvalid=%b wready=%b required 0 0000", c, S4_AWVALID, M_WREADY);
      end
      tick();
    end
    S4_BVALID = 1'b1;
    S4_BREADY = 1'b1;
    tick();
    S4_BVALID = 1'b0;
    S4_BREADY = 1'b0;
    checks++;
    if (OUTSTANDING !== 3'd3 || S4_AWVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL limit_after_b: got cnt=%0d awvalid=%b required cnt=3 awvalid=0", OUTSTANDING, S4_AWVALID);
    end
    tick();
    checks++;
    if (S4_AWVALID !== 1'b1 || AW_SEL !== 2'd0) begin
      failures++;
      $display("[TB] FAIL limit_regrant: got awvalid=%b sel=%0d required 1 0", S4_AWVALID, AW_SEL);
    end
    clear_inputs();
  endtask

  task automatic test_simultaneous_and_underflow();
    logic found = 1'b0;
    apply_reset();
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    M_AWVALID  = 4'b0001;
    M_WVALID   = 4'b0001;
    M_WLAST    = 4'b0001;
    for (int c = 0; c < 30 && !found; c++) begin
      if (OUTSTANDING == 3'd2 && S4_AWVALID) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL simul_setup: got no AW at count 2 required AW at count 2");
    end
    S4_BVALID = 1'b1;
    S4_BREADY = 1'b1;
    tick();
    S4_BVALID = 1'b0;
    S4_BREADY = 1'b0;
    M_AWVALID = '0;
    checks++;
    if (OUTSTANDING !== 3'd2) begin
      failures++;
      $display("[TB] FAIL simul_count: got %0d required 2", OUTSTANDING);
    end
    tick();
    M_WVALID = '0;
    M_WLAST  = '0;
    for (int i = 0; i < 2; i++) begin
      S4_BVALID = 1'b1;
      S4_BREADY = 1'b1;
      tick();
      S4_BVALID = 1'b0;
      S4_BREADY = 1'b0;
    end
    checks++;
    if (OUTSTANDING !== 3'd0 || B_UNDERFLOW !== 1'b0) begin
      failures++;
      $display("[TB] FAIL drain_count: got cnt=%0d uf=%b required cnt=0 uf=0", OUTSTANDING, B_UNDERFLOW);
    end
    S4_BVALID = 1'b1;
    S4_BREADY = 1'b1;
    tick();
    S4_BVALID = 1'b0;
    S4_BREADY = 1'b0;
    checks++;
    if (OUTSTANDING !== 3'd0 || B_UNDERFLOW !== 1'b1) begin
      failures++;
      $display("[TB] FAIL underflow_set: got cnt=%0d uf=%b required cnt=0 uf=1", OUTSTANDING, B_UNDERFLOW);
    end
    repeat (3) tick();
    checks++;
    if (B_UNDERFLOW !== 1'b1) begin
      failures++;
      $display("[TB] FAIL underflow_sticky: got %b required 1", B_UNDERFLOW);
    end
    apply_reset();
    checks++;
    if (B_UNDERFLOW !== 1'b0) begin
      failures++;
      $display("[TB] FAIL underflow_reset: got %b required 0", B_UNDERFLOW);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat   = 4'b1001;
    int         beats = 0;
    logic       done  = 1'b0;
    apply_reset();
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    M_AWVALID  = 4'b1010;
    tick();
    checks++;
    if (AW_SEL !== 2'd1) begin
      failures++;
      $display("[TB] FAIL bp_first_grant: got %0d required 1", AW_SEL);
    end
    tick();
    M_AWVALID = 4'b1000;
    M_WVALID  = 4'b0010;
    for (int c = 0; c < 40 && !done; c++) begin
      S4_WREADY = pat[c % 4];
      M_WLAST   = (beats == 7) ? 4'b0010 : 4'b0000;
      #1;
      checks++;
      if (M_WREADY !== (S4_WREADY ? 4'b0010 : 4'b0000) || W_SEL !== 2'd1) begin
        failures++;
        $display("[TB] FAIL bp_wready_c%0d: got wready=%b sel=%0d required wready=%b sel=1", c, M_WREADY, W_SEL, (S4_WREADY ? 4'b0010 : 4'b0000));
      end
      checks++;
      if (S4_AWVALID !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bp_no_aw_c%0d: got %b required 0", c, S4_AWVALID);
      end
      if (S4_WVALID && S4_WREADY) begin
        beats++;
        if (S4_WLAST) done = 1'b1;
      end
      tick();
    end
    M_WVALID  = '0;
    M_WLAST   = '0;
    S4_WREADY = 1'b1;
    checks++;
    if (beats !== 8 || !done) begin
      failures++;
      $display("[TB] FAIL bp_beats: got %0d done=%b required 8 done=1", beats, done);
    end
    checks++;
    if (S4_AWVALID !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_idle_turn: got %b required 0", S4_AWVALID);
    end
    tick();
    checks++;
    if (S4_AWVALID !== 1'b1 || AW_SEL !== 2'd3) begin
      failures++;
      $display("[TB] FAIL bp_second_grant: got awvalid=%b sel=%0d required 1 3", S4_AWVALID, AW_SEL);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    S4_AWREADY = 1'b1;
    S4_WREADY  = 1'b1;
    M_AWVALID  = 4'b0010;
    tick();
    tick();
    M_AWVALID = '0;
    M_WVALID  = 4'b0010;
    M_WLAST   = '0;
    tick();
    tick();
    checks++;
    if (S4_WVALID !== 1'b1 || OUTSTANDING !== 3'd1) begin
      failures++;
      $display("[TB] FAIL mid_pre: got wvalid=%b cnt=%0d required 1 1", S4_WVALID, OUTSTANDING);
    end
    #1;
    ARESET = 1'b1;
    #1;
    checks++;
    if ({S4_AWVALID, S4_WVALID, S4_WLAST, M_AWREADY, M_WREADY} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL mid_async_outputs: got %b required 0", {S4_AWVALID, S4_WVALID, S4_WLAST, M_AWREADY, M_WREADY});
    end
    checks++;
    if (OUTSTANDING !== 3'd0) begin
      failures++;
      $display("[TB] FAIL mid_async_count: got %0d required 0", OUTSTANDING);
    end
    M_WVALID = '0;
    @(negedge ACLK);
    ARESET    = 1'b0;
    M_AWVALID = 4'b1010;
    tick();
    checks++;
    if (S4_AWVALID !== 1'b1 || AW_SEL !== 2'd1) begin
      failures++;
      $display("[TB] FAIL mid_regrant: got awvalid=%b sel=%0d required 1 1", S4_AWVALID, AW_SEL);
    end
    clear_inputs();
  endtask

  // Run every scenario in order, then report
  initial begin
    ARESET = 1'b1;
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_outstanding_limit();
    test_simultaneous_and_underflow();
    test_back_to_back();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
